// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream word packer
package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_RATIO          = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } packer_state_t;

  // Lanes 0..idx set; callers size-cast down to their own lane count.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int idx);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      m[i] = (i <= idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_word_packer_if.sv
// rtl/stream_word_packer_if.sv - narrow input stream and wide output beat of the packer
interface stream_word_packer_if
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RATIO      = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]            out_keep;
  logic                        out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_word_packer.sv
// rtl/stream_word_packer.sv - packs RATIO narrow words into one wide beat with lane keep
module stream_word_packer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
  input logic                 clk,
  input logic                 rst,
  stream_word_packer_if.slave bus
);
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  packer_state_t        state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0]     keep_q, keep_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pend_last_q, pend_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]     out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;

  logic                 accept;
  logic                 complete;
  logic                 slot_free;
  logic [OUT_WIDTH-1:0] acc_ins;
  logic [RATIO-1:0]     keep_ins;

  assign bus.in_ready  = !rst && (state_q == COLLECT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign complete  = accept && ((idx_q == LAST_IDX) || bus.in_last);
  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    acc_ins = acc_q;
    acc_ins[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
    keep_ins = keep_q | RATIO'(keep_mask(int'(idx_q)));

    state_d     = state_q;
    acc_d       = acc_q;
    keep_d      = keep_q;
    idx_d       = idx_q;
    pend_last_d = pend_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    // A drain and a load on the same edge: the load below overrides this.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (complete) begin
            idx_d = '0;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_data_d  = acc_ins;
              out_keep_d  = keep_ins;
              out_last_d  = bus.in_last;
              acc_d       = '0;
              keep_d      = '0;
            end else begin
              acc_d       = acc_ins;
              keep_d      = keep_ins;
              pend_last_d = bus.in_last;
              state_d     = PENDING;
            end
          end else begin
            acc_d  = acc_ins;
            keep_d = keep_ins;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      PENDING: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_keep_d  = keep_q;
          out_last_d  = pend_last_q;
          acc_d       = '0;
          keep_d      = '0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      acc_q       <= '0;
      keep_q      <= '0;
      idx_q       <= '0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      idx_q       <= idx_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_stream_word_packer.sv
// tb/tb_stream_word_packer.sv - directed and scoreboarded bench for stream_word_packer
module tb_stream_word_packer;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  beat_t cap[$];
  beat_t exp_q[$];
  beat_t mon_b;
  bit   done;

  stream_word_packer_if #(.DATA_WIDTH(32), .RATIO(4)) bus ();

  stream_word_packer #(.DATA_WIDTH(32), .RATIO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_b.data = bus.out_data;
      mon_b.keep = bus.out_keep;
      mon_b.last = bus.out_last;
      cap.push_back(mon_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    bit rdy;
    int budget;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    budget = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 300);
    chk("send_accept", rdy, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int budget;
    budget = 0;
    while (cap.size() < n && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk(tag, cap.size(), n);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [127:0] d,
                          input logic [3:0] k, input logic l);
    if (i < cap.size()) begin
      chk({tag, "_data"}, cap[i].data, d);
      chk({tag, "_keep"}, cap[i].keep, k);
      chk({tag, "_last"}, cap[i].last, l);
    end else begin
      chk({tag, "_present"}, cap.size(), i + 1);
    end
  endtask

  initial begin
    logic [31:0]  w[200];
    bit           lw[200];
    logic [127:0] acc;
    logic [3:0]   kp;
    int           n;
    int           t0;
    int           in_lasts;
    int           out_lasts;

    checks = 0;
    errors = 0;
    cyc    = 0;
    done   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_ready_in_rst", bus.in_ready, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_out_keep", bus.out_keep, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", bus.in_ready, 1);

    // 2: full beat back-to-back
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    cap.delete();
    t0 = cyc;
    send(32'h11, 0);
    send(32'h22, 0);
    send(32'h33, 0);
    send(32'h44, 0);
    chk("t2_cycles", cyc - t0, 4);
    chk("t2_latency", bus.out_valid, 1);
    wait_beats("t2_count", 1);
    chk_beat("t2", 0, 128'h00000044_00000033_00000022_00000011, 4'hF, 0);
    @(posedge clk);
    #1;

    // 3: partial beat closed by in_last
    cap.delete();
    send(32'hA1, 0);
    send(32'hB2, 1);
    chk("t3_latency", bus.out_valid, 1);
    wait_beats("t3_count", 1);
    chk_beat("t3", 0, 128'h00000000_00000000_000000B2_000000A1, 4'b0011, 1);
    @(posedge clk);
    #1;

    // 4: backpressure into PENDING
    cap.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + i, 0);
    @(negedge clk);
    chk("t4_pending_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_data", bus.out_data, 128'h00000103_00000102_00000101_00000100);
      chk("t4_hold_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_beats("t4_count", 2);
    chk_beat("t4_b0", 0, 128'h00000103_00000102_00000101_00000100, 4'hF, 0);
    chk_beat("t4_b1", 1, 128'h00000107_00000106_00000105_00000104, 4'hF, 0);
    @(negedge clk);
    chk("t4_ready_back", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 5: random traffic against a reference grouping model
    cap.delete();
    exp_q.delete();
    in_lasts = 0;
    for (int i = 0; i < 200; i++) begin
      w[i]  = $urandom;
      lw[i] = (i == 199) || ($urandom_range(0, 4) == 0);
      if (lw[i]) in_lasts++;
    end
    acc = '0;
    kp  = '0;
    n   = 0;
    for (int i = 0; i < 200; i++) begin
      acc[n*32 +: 32] = w[i];
      kp[n] = 1'b1;
      if (n == 3 || lw[i]) begin
        exp_q.push_back('{acc, kp, lw[i]});
        acc = '0;
        kp  = '0;
        n   = 0;
      end else begin
        n++;
      end
    end
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(w[i], lw[i]);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_beats("t5_count", exp_q.size());
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_dup", cap.size(), exp_q.size());
    out_lasts = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_beat("t5", i, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
    end
    foreach (cap[i]) if (cap[i].last) out_lasts++;
    chk("t5_last_count", out_lasts, in_lasts);

    // 6: reset with a held beat and a partial beat in flight
    cap.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h500 + i, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_valid_in_rst", bus.out_valid, 0);
    chk("t6_ready_in_rst", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_quiet", cap.size(), 0);
    for (int i = 0; i < 4; i++) send(32'h600 + i, 0);
    wait_beats("t6_count", 1);
    chk_beat("t6", 0, 128'h00000603_00000602_00000601_00000600, 4'hF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
